mem_programa_param: RTL and testbench

- Parametrised, synchronous program memory for the accumulator CPU. Successor to the fixed 256x8 combinational instruction ROM.
- Has a registered fetch port with a valid/ready handshake, so the CPU can stall.
- Has a load port so programs are written at run time instead of hard-coded. Tracks load statistics.
- Clears itself after reset. Sits between the PC/fetch stage and the instruction decoder.

---
 rtl/mem_programa_param.sv | 162 ++++++++++++++++
 tb/tb_mem_programa_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_programa_param.sv
// Parametrised program memory for the accumulator CPU.
// Registered fetch port with valid/ready, run-time load port, self-clear after reset.
module mem_programa_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              modo_carga,
  input  logic              carga_we,
  input  logic [ADDR_W-1:0] carga_endereco,
  input  logic [DATA_W-1:0] carga_dado,
  input  logic              ler_req,
  input  logic [ADDR_W-1:0] ler_endereco,
  input  logic              cpu_pronto,
  output logic [DATA_W-1:0] instrucao_out,
  output logic              instrucao_valida,
  output logic              ler_aceito,
  output logic              ocupado,
  output logic              erro_endereco,
  output logic [ADDR_W:0]   palavras_carregadas,
  output logic [DATA_W-1:0] checksum
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {
    LIMPA,
    PRONTO,
    CARGA
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rd_oor;
  logic              wr_oor;
  logic [DATA_W-1:0] rd_word;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign rd_oor  = {1'b0, ler_endereco} >= DEPTH_L;
  assign wr_oor  = {1'b0, carga_endereco} >= DEPTH_L;
  assign rd_word = mem_q[ler_endereco[IDX_W-1:0]];

  // Next-state, fetch handshake, load accounting and memory write port mux.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    wr_en      = 1'b0;
    wr_addr    = ptr_q[IDX_W-1:0];
    wr_data    = FILL_WORD;
    ler_aceito = 1'b0;
    unique case (state_q)
      LIMPA: begin
        wr_en = 1'b1;
        if (ptr_q == LAST_L) begin
          state_d = PRONTO;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      PRONTO: begin
        ler_aceito = ler_req && (!valid_q || cpu_pronto);
        if (ler_aceito) begin
          valid_d = 1'b1;
          if (rd_oor) begin
            instr_d = FILL_WORD;
            err_d   = 1'b1;
          end else begin
            instr_d = rd_word;
          end
        end else if (valid_q && cpu_pronto) begin
          valid_d = 1'b0;
        end
        if (modo_carga) begin
          state_d = CARGA;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      CARGA: begin
        valid_d = 1'b0;
        if (carga_we) begin
          if (wr_oor) begin
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = carga_endereco[IDX_W-1:0];
            wr_data = carga_dado;
            sum_d   = sum_q + carga_dado;
            if (cnt_q != DEPTH_L) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        if (!modo_carga) begin
          state_d = PRONTO;
        end
      end
      default: begin
        state_d = LIMPA;
        ptr_d   = '0;
      end
    endcase
  end

  // Control and output registers; reset restarts the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LIMPA;
      ptr_q   <= '0;
      instr_q <= FILL_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  // Storage array: single write port shared by the sweep and the loader.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign instrucao_out       = instr_q;
  assign instrucao_valida    = valid_q;
  assign ocupado             = (state_q == LIMPA);
  assign erro_endereco       = err_q;
  assign palavras_carregadas = cnt_q;
  assign checksum            = sum_q;

endmodule

// File: tb/tb_mem_programa_param.sv
// Directed bench for mem_programa_param with a fetch scoreboard.
// A DEPTH=16 copy shares the stimulus for out-of-range cases.
module tb_mem_programa_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       modo, we, rq, pr;
  logic [7:0] ca, cd, ra;

  logic [7:0] out;
  logic       val, acc, ocup, err;
  logic [8:0] cnt;
  logic [7:0] sum;

  logic [7:0] o16;
  logic       v16, a16, oc16, e16;
  logic [8:0] c16;
  logic [7:0] s16;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  logic [7:0] q [$];

  always #5 clk = ~clk;

  mem_programa_param dut (
    .clk(clk), .rst_n(rst_n),
    .modo_carga(modo), .carga_we(we),
    .carga_endereco(ca), .carga_dado(cd),
    .ler_req(rq), .ler_endereco(ra), .cpu_pronto(pr),
    .instrucao_out(out), .instrucao_valida(val),
    .ler_aceito(acc), .ocupado(ocup),
    .erro_endereco(err),
    .palavras_carregadas(cnt), .checksum(sum)
  );

  mem_programa_param #(.DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .modo_carga(modo), .carga_we(we),
    .carga_endereco(ca), .carga_dado(cd),
    .ler_req(rq), .ler_endereco(ra), .cpu_pronto(pr),
    .instrucao_out(o16), .instrucao_valida(v16),
    .ler_aceito(a16), .ocupado(oc16),
    .erro_endereco(e16),
    .palavras_carregadas(c16), .checksum(s16)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic w,
                      input logic [7:0] a, input logic [7:0] d,
                      input logic r, input logic [7:0] ad,
                      input logic p, output logic acc_o);
    modo = m; we = w; ca = a; cd = d;
    rq = r; ra = ad; pr = p;
    #1;
    if (val && pr) begin
      if (q.size() == 0) chk("sb_empty", 32'(val), 32'd0);
      else chk("sb_word", 32'(out), 32'(q.pop_front()));
    end
    acc_o = acc;
    if (acc) q.push_back(model[ad]);
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    logic x;
    step(1'b1, 1'b1, a, d, 1'b0, 8'h00, 1'b0, x);
    model[a] = d;
  endtask

  task automatic sweep(input int limit, output int n, output int bad);
    n = 0; bad = 0;
    while (ocup && n < limit) begin
      if (acc) bad++;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic a;
    int n, bad;
    logic [7:0] esum;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rst_n = 1'b0;
    modo = 0; we = 0; ca = 0; cd = 0;
    rq = 1; ra = 8'h05; pr = 1;
    #3;
    chk("rst_ocupado", 32'(ocup), 32'd1);
    chk("rst_valid", 32'(val), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    sweep(400, n, bad);
    chk("sweep_len", 32'(n), 32'd256);
    chk("sweep_acc", 32'(bad), 32'd0);

    step(0, 0, 8'h00, 8'h00, 1, 8'h05, 1, a);
    chk("first_acc", 32'(a), 32'd1);
    chk("first_valid", 32'(val), 32'd1);
    chk("first_out", 32'(out), 32'h00);
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);
    chk("consume_valid", 32'(val), 32'd0);

    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);
    load(8'h00, 8'h61);
    load(8'h01, 8'h37);
    load(8'h02, 8'h47);
    load(8'h03, 8'h69);
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);
    chk("load_cnt", 32'(cnt), 32'd4);
    chk("load_sum", 32'(sum), 32'h48);

    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 8'h00, 1, 8'(i), 1, a);
      chk("b2b_acc", 32'(a), 32'd1);
      chk("b2b_valid", 32'(val), 32'd1);
    end
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);
    chk("b2b_queue", 32'(q.size()), 32'd0);

    step(0, 0, 8'h00, 8'h00, 1, 8'h01, 1, a);
    chk("stall_first_acc", 32'(a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 8'h00, 1, 8'h02, 0, a);
      chk("stall_acc", 32'(a), 32'd0);
      chk("stall_out", 32'(out), 32'h37);
      chk("stall_valid", 32'(val), 32'd1);
    end
    step(0, 0, 8'h00, 8'h00, 1, 8'h02, 1, a);
    chk("unstall_acc", 32'(a), 32'd1);
    chk("unstall_out", 32'(out), 32'h47);
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);

    step(0, 0, 8'h00, 8'h00, 1, 8'h20, 1, a);
    chk("oor_acc16", 32'(a16), 32'd1);
    chk("oor_out16", 32'(o16), 32'h00);
    chk("oor_valid16", 32'(v16), 32'd1);
    chk("oor_err16", 32'(e16), 32'd1);
    chk("oor_err_main", 32'(err), 32'd0);
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);
    chk("oor_err16_end", 32'(e16), 32'd0);

    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);
    load(8'h10, 8'hAB);
    chk("oorld_err16", 32'(e16), 32'd1);
    chk("oorld_cnt16", 32'(c16), 32'd0);
    chk("oorld_sum16", 32'(s16), 32'd0);
    chk("oorld_cnt", 32'(cnt), 32'd1);
    chk("oorld_err_main", 32'(err), 32'd0);
    load(8'h02, 8'h05);
    chk("ld_err16_end", 32'(e16), 32'd0);
    chk("ld_cnt16", 32'(c16), 32'd1);
    chk("ld_sum16", 32'(s16), 32'h05);
    step(0, 1, 8'h03, 8'h10, 0, 8'h00, 1, a);
    model[3] = 8'h10;
    chk("exit_cnt", 32'(cnt), 32'd3);
    chk("exit_sum", 32'(sum), 32'hC0);
    chk("exit_cnt16", 32'(c16), 32'd2);
    chk("exit_sum16", 32'(s16), 32'h15);
    step(0, 0, 8'h00, 8'h00, 1, 8'h03, 1, a);
    chk("vis_acc", 32'(a), 32'd1);
    chk("vis_out", 32'(out), 32'h10);
    step(0, 0, 8'h00, 8'h00, 1, 8'h10, 1, a);
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);
    chk("hold_cnt", 32'(cnt), 32'd3);

    step(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, a);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, a);
    chk("pend_valid", 32'(val), 32'd1);
    chk("entry_cnt", 32'(cnt), 32'd0);
    chk("entry_sum", 32'(sum), 32'd0);
    step(1, 0, 8'h00, 8'h00, 1, 8'h01, 0, a);
    chk("carga_acc", 32'(a), 32'd0);
    chk("pend_clear", 32'(val), 32'd0);
    q.delete();
    esum = 8'h00;
    for (int i = 0; i < 300; i++) begin
      load(8'h00, 8'(i));
      esum = esum + 8'(i);
      if (i == 254) chk("cnt_255", 32'(cnt), 32'd255);
    end
    chk("sat_cnt", 32'(cnt), 32'd256);
    chk("sat_sum", 32'(sum), 32'(esum));
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);
    step(0, 0, 8'h00, 8'h00, 1, 8'h00, 1, a);
    chk("sat_out", 32'(out), 32'h2B);
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, a);

    rq = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'h00);
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_ocupado", 32'(ocup), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(100, n, bad);
    chk("mid_ocupado", 32'(ocup), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ocupado", 32'(ocup), 32'd1);
    chk("mid_rst_valid", 32'(val), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(400, n, bad);
    chk("resweep_len", 32'(n), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
